// File: rtl/key_debouncer_if.sv
// Button bundle between the raw board pins and the debounced player-choice side.
// The debouncer takes the slave view; whoever drives the buttons takes the master view.
interface key_debouncer_if #(
  parameter int NUM_KEYS = 2
);
  logic [NUM_KEYS-1:0] i_KEY;
  logic [NUM_KEYS-1:0] o_KEY;
  logic [NUM_KEYS-1:0] o_press;
  logic [NUM_KEYS-1:0] o_release;

  modport master (
    output i_KEY,
    input  o_KEY,
    input  o_press,
    input  o_release
  );

  modport slave (
    input  i_KEY,
    output o_KEY,
    output o_press,
    output o_release
  );
endinterface

// File: rtl/key_debouncer.sv
// Per-channel push-button debouncer: two-flop synchronizer, stability counter,
// registered debounced level (active-low) and one-cycle press/release pulses.
module key_debouncer #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  key_debouncer_if.slave  keys
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [NUM_KEYS-1:0] level_vec;
  logic [NUM_KEYS-1:0] press_vec;
  logic [NUM_KEYS-1:0] release_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic          sync1_reg;
      logic          sync2_reg;
      logic          stable_reg;
      logic          stable_next;
      logic [CW-1:0] count_reg;
      logic [CW-1:0] count_next;
      logic          press_reg;
      logic          press_next;
      logic          release_reg;
      logic          release_next;

      // Any cycle where the synchronized level matches the accepted level
      // restarts qualification, so a single-cycle bounce costs a full window.
      always_comb begin
        stable_next  = stable_reg;
        count_next   = count_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (sync2_reg == stable_reg) begin
          count_next = '0;
        end else if (count_reg == CNT_LAST) begin
          stable_next  = sync2_reg;
          count_next   = '0;
          press_next   = ~sync2_reg;
          release_next = sync2_reg;
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end

      always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
          sync1_reg   <= 1'b1;
          sync2_reg   <= 1'b1;
          stable_reg  <= 1'b1;
          count_reg   <= '0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          sync1_reg   <= keys.i_KEY[gi];
          sync2_reg   <= sync1_reg;
          stable_reg  <= stable_next;
          count_reg   <= count_next;
          press_reg   <= press_next;
          release_reg <= release_next;
        end
      end

      assign level_vec[gi]   = stable_reg;
      assign press_vec[gi]   = press_reg;
      assign release_vec[gi] = release_reg;
    end
  endgenerate

  assign keys.o_KEY     = level_vec;
  assign keys.o_press   = press_vec;
  assign keys.o_release = release_vec;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, NUM_KEYS=2.
// Row k: inputs applied before edge k, outputs checked 2 ns after edge k.
module tb_key_debouncer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  key_debouncer_if #(.NUM_KEYS(2)) keys ();

  key_debouncer #(
    .NUM_KEYS        (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .keys      (keys)
  );

  typedef struct {
    logic       rst_n;
    logic [1:0] key;
    logic [1:0] exp_level;
    logic [1:0] exp_press;
    logic [1:0] exp_release;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input int n, input logic r, input logic [1:0] k,
                     input logic [1:0] lv, input logic [1:0] pr, input logic [1:0] rl);
    vec_t v;
    v.rst_n = r; v.key = k; v.exp_level = lv; v.exp_press = pr; v.exp_release = rl;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%b want=%b", name, row, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [1:0] k);
    rst_n      = r;
    keys.i_KEY = k;
    @(posedge clk);
    #2;
  endtask

  int press_cnt;

  initial begin
    rst_n      = 1'b0;
    keys.i_KEY = 2'b00;

    // Reset with both keys held, then both press 6 edges after reset release.
    add(3, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00);
    add(5, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b11, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(5, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b11);
    add(1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    // Clean press on key 0, held, released 20 edges later.
    add(5,  1'b1, 2'b10, 2'b11, 2'b00, 2'b00);
    add(1,  1'b1, 2'b10, 2'b10, 2'b01, 2'b00);
    add(14, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00);
    add(5,  1'b1, 2'b11, 2'b10, 2'b00, 2'b00);
    add(1,  1'b1, 2'b11, 2'b11, 2'b00, 2'b01);
    add(2,  1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    // Key 1 bursts 0,1,0,1: rejected.
    add(1, 1'b1, 2'b01, 2'b11, 2'b00, 2'b00);
    add(1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    add(1, 1'b1, 2'b01, 2'b11, 2'b00, 2'b00);
    add(9, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    // Key 0 low 3, high 1, then low held: press 6 edges after final fall.
    add(3, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00);
    add(1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    add(5, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00);
    add(1, 1'b1, 2'b10, 2'b10, 2'b01, 2'b00);
    add(1, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00);
    add(5, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00);
    add(1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b01);
    add(1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    // Both keys fall together, then release together.
    add(5, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b11, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(5, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b11);
    add(1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    // Reset 2 cycles into a press: no pulse, full re-qualification after.
    add(2, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00);
    add(2, 1'b0, 2'b10, 2'b11, 2'b00, 2'b00);
    add(5, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00);
    add(1, 1'b1, 2'b10, 2'b10, 2'b01, 2'b00);
    add(1, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00);
    add(5, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00);
    add(1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b01);
    add(2, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00);

    for (int r = 0; r < vecs.size(); r++) begin
      cycle(vecs[r].rst_n, vecs[r].key);
      chk("o_KEY",     r, keys.o_KEY,     vecs[r].exp_level);
      chk("o_press",   r, keys.o_press,   vecs[r].exp_press);
      chk("o_release", r, keys.o_release, vecs[r].exp_release);
    end

    // Long hold: exactly one press pulse, never press with release.
    press_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      cycle(1'b1, 2'b10);
      if (keys.o_press[0] === 1'b1) press_cnt++;
      chk("no_overlap", c, keys.o_press & keys.o_release, 2'b00);
    end
    chk("hold_press_count", 60, 2'(press_cnt), 2'd1);
    chk("hold_level", 60, keys.o_KEY, 2'b10);

    // Reset forces released level regardless of raw input.
    cycle(1'b0, 2'b00);
    chk("rst_level",   0, keys.o_KEY,     2'b11);
    chk("rst_press",   0, keys.o_press,   2'b00);
    chk("rst_release", 0, keys.o_release, 2'b00);

    // Released keys after reset: no spurious pulses.
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 2'b11);
      chk("idle_pulses", c, keys.o_press | keys.o_release, 2'b00);
    end
    chk("idle_level", 10, keys.o_KEY, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter NUM_KEYS, default 2: number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive stable cycles required to accept a level change; legal range >= 2.
REQ-003 i_clk  input  1  system clock; single clock domain; all state on rising edge.
REQ-004 i_reset_n  input  1  synchronous, active-low reset.
REQ-005 i_KEY  input  NUM_KEYS  raw board buttons, asynchronous, active-low (0 = pushed).
REQ-006 o_KEY  output  NUM_KEYS  debounced button levels, active-low; drives the player-choice stage's i_KEY.
REQ-007 o_press  output  NUM_KEYS  one-cycle pulse per channel when its debounced level goes 1->0.
REQ-008 o_release  output  NUM_KEYS  one-cycle pulse per channel when its debounced level goes 0->1.

Function
REQ-009 Each channel SHALL pass i_KEY through a two-flop synchronizer before any other logic; no combinational path from i_KEY to any output.
REQ-010 Each channel SHALL hold a registered stable level (drives o_KEY) and a counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-011 Each cycle that synchronized level equals stable level, the counter SHALL clear to 0.
REQ-012 Each cycle that synchronized level differs from stable level and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 When they differ and counter == DEBOUNCE_CYCLES-1, on that edge the stable level SHALL take the synchronized value and the counter SHALL clear to 0.
REQ-014 Any single-cycle return of the synchronized level to the stable value SHALL restart qualification from 0 (glitch rejection).
REQ-015 Latency: a clean raw transition at edge t SHALL appear on o_KEY at edge t+2+DEBOUNCE_CYCLES.
REQ-016 o_press[i] SHALL be 1 for exactly the cycle in which o_KEY[i] first reads 0 after reading 1; o_release[i] likewise for 0->1; both registered.
REQ-017 o_press[i] and o_release[i] SHALL never be high in the same cycle; pulses SHALL not repeat while a level is held.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several keys SHALL each qualify and pulse on their own schedule, possibly in the same cycle.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-020 While i_reset_n == 0 at a rising edge: synchronizer flops and stable levels SHALL load 1 (released), counters 0, o_press and o_release 0.
REQ-021 o_KEY SHALL read all-ones the cycle after reset is sampled, regardless of i_KEY.
REQ-022 Reset asserted mid-qualification SHALL discard the partial count; no pulse SHALL be emitted for that transition.
REQ-023 A button held down through reset release SHALL qualify from 0 and produce o_press at edge 2+DEBOUNCE_CYCLES after the first non-reset edge.

Verification (DEBOUNCE_CYCLES=4, NUM_KEYS=2)
REQ-024 Reset with i_KEY=2'b00 -> o_KEY=2'b11, o_press=o_release=0 on first post-reset cycle; o_press=2'b11 for one cycle 6 edges after reset release.
REQ-025 i_KEY[0] 1->0 at edge t, held -> o_KEY[0]=0 from edge t+6, o_press[0]=1 only at t+6; release at t+20 -> o_KEY[0]=1 and o_release[0]=1 only at t+26.
REQ-026 i_KEY[1] bursts 0,1,0,1 (one cycle each) then stays 1 -> o_KEY[1] stays 1, no pulses.
REQ-027 i_KEY[0] low 3 cycles, high 1, low held -> o_press[0] fires 6 edges after the final falling edge, not earlier.
REQ-028 Both keys fall on the same edge -> o_press=2'b11 in the same single cycle.
REQ-029 Reset asserted 2 cycles into a qualifying press -> no o_press; counters 0 after reset; re-qualification takes a full 6 edges.
